// File: rtl/rs_dispatch_pkg.sv
// rs_dispatch shared types: sizes, unit codes, ready tag,
// entry-state encoding and the operand-resolve helper.
package rs_dispatch_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 6;
  localparam int UNIT_SIZE = 8;
  localparam int NUM_REGS  = 1 << REG_SIZE;

  typedef logic [UNIT_SIZE-1:0] tag_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  localparam tag_t READY_TAG = 8'h7F;

  localparam logic [2:0] UNIT_LW  = 3'b000;
  localparam logic [2:0] UNIT_SW  = 3'b001;
  localparam logic [2:0] UNIT_ADD = 3'b010;
  localparam logic [2:0] UNIT_MUL = 3'b011;
  localparam logic [2:0] UNIT_MV  = 3'b100;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_ISSUED = 2'd3
  } ent_st_e;

  typedef struct packed {
    ent_st_e    st;
    logic [2:0] unit;
    tag_t       qj;
    tag_t       qk;
    word_t      vj;
    word_t      vk;
    word_t      imm;
  } rs_entry_t;

  typedef struct packed {
    tag_t  q;
    word_t v;
  } opnd_t;

  // Units that write a destination register and so rename it.
  function automatic logic renames(input logic [2:0] u);
    return u inside {UNIT_LW, UNIT_ADD, UNIT_MUL, UNIT_MV};
  endfunction

  // Status tag -> operand; bh/bt/bv let a same-cycle result be captured.
  function automatic opnd_t resolve(
    input tag_t  t,
    input word_t rv,
    input logic  bh,
    input tag_t  bt,
    input word_t bv
  );
    opnd_t o;
    o = '{q: t, v: '0};
    if (t == READY_TAG) o.v = rv;
    else if (bh && t == bt) o = '{q: READY_TAG, v: bv};
    return o;
  endfunction

endpackage

// File: rtl/rs_dispatch_prio_pick.sv
// rs_prio_pick: lowest-index one-hot grant from a request vector.
// Used for both free-slot allocation and ready-slot issue.
module rs_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // Isolate the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/rs_dispatch.sv
// rs_dispatch: reservation station + register status table.
// RS_CDB_BYPASS_EN: dispatch captures a same-cycle CDB result.
module rs_dispatch
  import rs_dispatch_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2:0]           in_unit,
  input  logic [REG_SIZE-1:0]  in_reg1,
  input  logic [REG_SIZE-1:0]  in_reg2,
  input  logic [REG_SIZE-1:0]  in_reg3,
  input  logic                 in_hasimm,
  input  logic [WORD_SIZE-1:0] in_imm,
  output logic                 in_accept,
  input  logic [REG_SIZE-1:0]  rd_reg,
  output logic [UNIT_SIZE-1:0] rd_tag,
  output logic [WORD_SIZE-1:0] rd_value,
  input  logic                 cdb_valid,
  input  logic [UNIT_SIZE-1:0] cdb_tag,
  input  logic [WORD_SIZE-1:0] cdb_value,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [2:0]           ex_unit,
  output logic [UNIT_SIZE-1:0] ex_tag,
  output logic [WORD_SIZE-1:0] ex_vj,
  output logic [WORD_SIZE-1:0] ex_vk,
  output logic [WORD_SIZE-1:0] ex_imm
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam rs_entry_t ENT_RST = '{
    st: ST_FREE, unit: '0, qj: READY_TAG, qk: READY_TAG,
    vj: '0, vk: '0, imm: '0
  };

  rs_entry_t ent_q [ENTRIES];
  rs_entry_t ent_d [ENTRIES];
  tag_t      stat_q [NUM_REGS];
  word_t     rf_q [NUM_REGS];

  logic [ENTRIES-1:0] free_vec, free_gnt;
  logic [ENTRIES-1:0] rdy_vec, rdy_gnt;
  logic               free_any, rdy_any;
  logic [IW-1:0]      free_idx, rdy_idx;

  logic          ex_valid_q;
  logic [IW-1:0] ex_idx_q;
  logic [2:0]    ex_unit_q;
  word_t         ex_vj_q, ex_vk_q, ex_imm_q;

  logic      cdb_hit, byp_en, hs, load;
  rs_entry_t new_ent;
  opnd_t     oj, ok;

  assign cdb_hit = cdb_valid && (cdb_tag != READY_TAG);
  assign hs      = ex_valid_q && ex_ready;
  assign load    = !ex_valid_q || ex_ready;

`ifdef RS_CDB_BYPASS_EN
  assign byp_en    = cdb_hit;
  assign in_accept = in_valid & free_any & ~rst;
`else
  assign byp_en    = 1'b0;
  assign in_accept = in_valid & free_any & ~rst & ~cdb_valid;
`endif

  assign rd_tag   = stat_q[rd_reg];
  assign rd_value = rf_q[rd_reg];

  assign ex_valid = ex_valid_q;
  assign ex_unit  = ex_unit_q;
  assign ex_tag   = UNIT_SIZE'(ex_idx_q);
  assign ex_vj    = ex_vj_q;
  assign ex_vk    = ex_vk_q;
  assign ex_imm   = ex_imm_q;

  // Candidate vectors; the presented entry is not picked again.
  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i] = ent_q[i].st == ST_FREE;
      rdy_vec[i]  = (ent_q[i].st == ST_READY) &&
                    !(ex_valid_q && ex_idx_q == IW'(i));
    end
  end

  rs_prio_pick #(.N(ENTRIES)) u_free_pick (
    .req_i (free_vec),
    .gnt_o (free_gnt),
    .any_o (free_any)
  );

  rs_prio_pick #(.N(ENTRIES)) u_rdy_pick (
    .req_i (rdy_vec),
    .gnt_o (rdy_gnt),
    .any_o (rdy_any)
  );

  // One-hot grants to indices.
  always_comb begin
    free_idx = '0;
    rdy_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (free_gnt[i]) free_idx = IW'(i);
      if (rdy_gnt[i])  rdy_idx  = IW'(i);
    end
  end

  // Build the entry for the incoming instruction.
  always_comb begin
    oj = resolve(stat_q[in_reg2], rf_q[in_reg2],
                 byp_en, cdb_tag, cdb_value);
    ok = '{q: READY_TAG, v: '0};
    unique case (1'b1)
      (in_unit == UNIT_MV): begin
        if (in_hasimm) oj = '{q: READY_TAG, v: in_imm};
      end
      (in_unit == UNIT_SW): begin
        ok = resolve(stat_q[in_reg1], rf_q[in_reg1],
                     byp_en, cdb_tag, cdb_value);
      end
      (in_unit == UNIT_ADD) || (in_unit == UNIT_MUL): begin
        if (in_hasimm) ok = '{q: READY_TAG, v: in_imm};
        else ok = resolve(stat_q[in_reg3], rf_q[in_reg3],
                          byp_en, cdb_tag, cdb_value);
      end
      default: ;
    endcase
    new_ent.st   = (oj.q == READY_TAG && ok.q == READY_TAG)
                   ? ST_READY : ST_WAIT;
    new_ent.unit = in_unit;
    new_ent.qj   = oj.q;
    new_ent.vj   = oj.v;
    new_ent.qk   = ok.q;
    new_ent.vk   = ok.v;
    new_ent.imm  = in_hasimm ? in_imm : '0;
  end

  // Per-entry next state: allocate, wake, issue, retire.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      unique case (ent_q[i].st)
        ST_FREE: begin
          if (in_accept && free_gnt[i]) ent_d[i] = new_ent;
        end
        ST_WAIT: begin
          if (cdb_hit && ent_q[i].qj == cdb_tag) begin
            ent_d[i].qj = READY_TAG;
            ent_d[i].vj = cdb_value;
          end
          if (cdb_hit && ent_q[i].qk == cdb_tag) begin
            ent_d[i].qk = READY_TAG;
            ent_d[i].vk = cdb_value;
          end
          if (ent_d[i].qj == READY_TAG &&
              ent_d[i].qk == READY_TAG)
            ent_d[i].st = ST_READY;
        end
        ST_READY: begin
          if (hs && ex_idx_q == IW'(i))
            ent_d[i].st = (ent_q[i].unit == UNIT_SW)
                          ? ST_FREE : ST_ISSUED;
        end
        ST_ISSUED: begin
          if (cdb_hit && cdb_tag == UNIT_SIZE'(i))
            ent_d[i].st = ST_FREE;
        end
        default: ent_d[i].st = ST_FREE;
      endcase
    end
  end

  // Entry state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ENT_RST;
    end else begin
      ent_q <= ent_d;
    end
  end

  // Register file and status: CDB writeback, then rename wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        stat_q[r] <= READY_TAG;
        rf_q[r]   <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cdb_hit && stat_q[r] == cdb_tag) begin
          rf_q[r]   <= cdb_value;
          stat_q[r] <= READY_TAG;
        end
      end
      if (in_accept && renames(in_unit))
        stat_q[in_reg1] <= UNIT_SIZE'(free_idx);
    end
  end

  // Issue register: load next ready entry when empty or taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_idx_q   <= '0;
      ex_unit_q  <= '0;
      ex_vj_q    <= '0;
      ex_vk_q    <= '0;
      ex_imm_q   <= '0;
    end else if (load) begin
      ex_valid_q <= rdy_any;
      if (rdy_any) begin
        ex_idx_q  <= rdy_idx;
        ex_unit_q <= ent_q[rdy_idx].unit;
        ex_vj_q   <= ent_q[rdy_idx].vj;
        ex_vk_q   <= ent_q[rdy_idx].vk;
        ex_imm_q  <= ent_q[rdy_idx].imm;
      end
    end
  end

endmodule

// File: tb/tb_rs_dispatch.sv
// tb_rs_dispatch: random dispatch/CDB/issue traffic against
// a behavioural reservation-station model.
module tb_rs_dispatch;

  localparam int E    = 4;
  localparam int NCYC = 3000;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_unit;
  logic [5:0]  in_reg1, in_reg2, in_reg3;
  logic        in_hasimm;
  logic [31:0] in_imm;
  logic        in_accept;
  logic [5:0]  rd_reg;
  logic [7:0]  rd_tag;
  logic [31:0] rd_value;
  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_unit;
  logic [7:0]  ex_tag;
  logic [31:0] ex_vj, ex_vk, ex_imm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_dispatch #(.ENTRIES(E)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_unit   (in_unit),
    .in_reg1   (in_reg1),
    .in_reg2   (in_reg2),
    .in_reg3   (in_reg3),
    .in_hasimm (in_hasimm),
    .in_imm    (in_imm),
    .in_accept (in_accept),
    .rd_reg    (rd_reg),
    .rd_tag    (rd_tag),
    .rd_value  (rd_value),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_unit   (ex_unit),
    .ex_tag    (ex_tag),
    .ex_vj     (ex_vj),
    .ex_vk     (ex_vk),
    .ex_imm    (ex_imm)
  );

  // Reference model: busy/issued flags, pending producer
  // (-1 = value present), register status (-1 = in file).
  bit          mb [E];
  bit          mi [E];
  logic [2:0]  mu [E];
  int          mqj [E];
  int          mqk [E];
  logic [31:0] mvj [E];
  logic [31:0] mvk [E];
  logic [31:0] mim [E];
  int          st [64];
  logic [31:0] rf [64];
  bit          pv;
  int          pidx;
  logic [2:0]  pu;
  logic [31:0] pvj, pvk, pim;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  function automatic int find_free();
    for (int i = 0; i < E; i++) if (!mb[i]) return i;
    return -1;
  endfunction

  function automatic bit exp_accept();
    return in_valid && !rst && find_free() >= 0 &&
           (BYP || !cdb_valid);
  endfunction

  task automatic resolve(input int r, output int q,
                         output logic [31:0] v);
    q = -1;
    v = '0;
    if (st[r] < 0) v = rf[r];
    else if (BYP && cdb_valid && st[r] == int'(cdb_tag))
      v = cdb_value;
    else q = st[r];
  endtask

  task automatic model_step();
    int al, cd, nqj, nqk;
    logic [31:0] nvj, nvk;
    bit acc;
    if (rst) begin
      for (int i = 0; i < E; i++) begin
        mb[i] = 0;
        mi[i] = 0;
      end
      for (int r = 0; r < 64; r++) begin
        st[r] = -1;
        rf[r] = '0;
      end
      pv = 0;
      return;
    end
    al  = find_free();
    acc = exp_accept();
    cd  = -1;
    for (int i = E - 1; i >= 0; i--)
      if (mb[i] && !mi[i] && mqj[i] < 0 && mqk[i] < 0 &&
          !(pv && pidx == i)) cd = i;
    nqj = -1; nvj = '0; nqk = -1; nvk = '0;
    if (in_unit == 3'd4 && in_hasimm) nvj = in_imm;
    else resolve(int'(in_reg2), nqj, nvj);
    if (in_unit == 3'd1) resolve(int'(in_reg1), nqk, nvk);
    else if (in_unit == 3'd2 || in_unit == 3'd3) begin
      if (in_hasimm) nvk = in_imm;
      else resolve(int'(in_reg3), nqk, nvk);
    end
    if (cdb_valid) begin
      for (int i = 0; i < E; i++) begin
        if (!mb[i]) continue;
        if (mi[i] && i == int'(cdb_tag)) begin
          mb[i] = 0;
          mi[i] = 0;
        end else if (!mi[i]) begin
          if (mqj[i] == int'(cdb_tag)) begin
            mqj[i] = -1;
            mvj[i] = cdb_value;
          end
          if (mqk[i] == int'(cdb_tag)) begin
            mqk[i] = -1;
            mvk[i] = cdb_value;
          end
        end
      end
      for (int r = 0; r < 64; r++)
        if (st[r] == int'(cdb_tag)) begin
          rf[r] = cdb_value;
          st[r] = -1;
        end
    end
    if (pv && ex_ready) begin
      mi[pidx] = 1;
      if (mu[pidx] == 3'd1) begin
        mb[pidx] = 0;
        mi[pidx] = 0;
      end
    end
    if (!pv || ex_ready) begin
      pv = cd >= 0;
      if (pv) begin
        pidx = cd;
        pu   = mu[cd];
        pvj  = mvj[cd];
        pvk  = mvk[cd];
        pim  = mim[cd];
      end
    end
    if (acc) begin
      mb[al]  = 1;
      mi[al]  = 0;
      mu[al]  = in_unit;
      mqj[al] = nqj;
      mvj[al] = nvj;
      mqk[al] = nqk;
      mvk[al] = nvk;
      mim[al] = in_hasimm ? in_imm : '0;
      if (in_unit != 3'd1) st[in_reg1] = al;
    end
  endtask

  task automatic drive(input int cyc);
    int iss [$];
    rst       = (cyc < 2) || ($urandom_range(0, 299) == 0);
    in_valid  = (cyc >= 64) && ($urandom_range(0, 3) != 0);
    in_unit   = 3'($urandom_range(0, 4));
    in_reg1   = 6'($urandom_range(0, 7));
    in_reg2   = 6'($urandom_range(0, 7));
    in_reg3   = 6'($urandom_range(0, 7));
    in_hasimm = 1'($urandom_range(0, 1));
    in_imm    = $urandom;
    rd_reg    = (cyc < 64) ? 6'(cyc)
                           : 6'($urandom_range(0, 7));
    ex_ready  = ((cyc % 150) < 30) ? 1'b0
                : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < E; i++)
      if (mb[i] && mi[i]) iss.push_back(i);
    cdb_valid = 1'b0;
    cdb_tag   = 8'($urandom_range(0, E - 1));
    cdb_value = $urandom;
    if (iss.size() > 0 && $urandom_range(0, 1) == 1) begin
      cdb_valid = 1'b1;
      cdb_tag   = 8'(iss[$urandom_range(0, iss.size() - 1)]);
    end
  endtask

  task automatic compare();
    logic [7:0] et;
    check("in_accept", 32'(in_accept), 32'(exp_accept()));
    et = (st[rd_reg] < 0) ? 8'h7F : 8'(st[rd_reg]);
    check("rd_tag", 32'(rd_tag), 32'(et));
    if (st[rd_reg] < 0) check("rd_value", rd_value, rf[rd_reg]);
    check("ex_valid", 32'(ex_valid), 32'(pv));
    if (pv && ex_valid) begin
      check("ex_tag", 32'(ex_tag), 32'(pidx));
      check("ex_unit", 32'(ex_unit), 32'(pu));
      check("ex_vj", ex_vj, pvj);
      check("ex_vk", ex_vk, pvk);
      check("ex_imm", ex_imm, pim);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_unit = '0;
    in_reg1 = '0; in_reg2 = '0; in_reg3 = '0;
    in_hasimm = 1'b0; in_imm = '0; rd_reg = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    ex_ready = 1'b0; pv = 0; pidx = 0;
    for (int i = 0; i < E; i++) begin
      mb[i] = 0; mi[i] = 0;
    end
    for (int r = 0; r < 64; r++) begin
      st[r] = -1; rf[r] = '0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      drive(cyc);
      @(negedge clk);
      compare();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
